pe_load_sequencer: RTL

- Upstream stage of the PE one-hot write decoder: turns a streamed burst of operand words into sequential write-address/enable strobes plus registered write data.
- Its address/enable output drives the decoder's addr/en inputs directly; the decoder's one-hot output selects the PE register bank entry.
- Handles burst start, valid/ready input handshake, address wrap-around, abort and completion signalling.

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_load_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Brief    : Shared types and widths for the PE load sequencer and decoder.
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

  // Bank address width shared by the sequencer and the one-hot decoder.
  localparam int PE_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } pe_ld_state_t;

endpackage
`default_nettype wire

// File: rtl/pe_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pe_load_sequencer
// Brief    : Turns a streamed operand burst into sequential decoder write
//            strobes with registered address and data.
// Revision : 1.0 - initial release
// ============================================================================
module pe_load_sequencer
  import pe_pkg::*;
#(
  parameter  int ADDR_WIDTH = PE_ADDR_WIDTH,
  parameter  int DATA_WIDTH = 8,
  localparam int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] dec_addr,
  output logic                  dec_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                 CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = CNT_WIDTH'(DEPTH);

  pe_ld_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] dec_addr_q, dec_addr_d;
  logic                  dec_en_q, dec_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic handshake;
  logic last_word;

  // Abort gates in_ready combinationally so a word offered alongside abort is refused.
  assign in_ready  = (state_q == LOAD) && !abort;
  assign handshake = in_valid && in_ready;
  assign last_word = (count_q == (len_q - CNT_WIDTH'(1)));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    count_d    = count_q;
    dec_addr_d = dec_addr_q;
    wr_data_d  = wr_data_q;
    dec_en_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          count_d = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            ptr_d   = base_addr;
            len_d   = (len > DEPTH_C) ? DEPTH_C : len;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (handshake) begin
          dec_en_d   = 1'b1;
          dec_addr_d = ptr_q;
          wr_data_d  = in_data;
          ptr_d      = ptr_q + ADDR_WIDTH'(1);
          count_d    = count_q + CNT_WIDTH'(1);
          if (last_word) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      count_q    <= '0;
      dec_addr_q <= '0;
      dec_en_q   <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      count_q    <= count_d;
      dec_addr_q <= dec_addr_d;
      dec_en_q   <= dec_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dec_addr = dec_addr_q;
  assign dec_en   = dec_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule
`default_nettype wire
